// File: rtl/exhaustive_stim_gen_pkg.sv
// Shared definitions for the exhaustive stimulus sequencer: FSM encodings
// and the hold counter width.
package exhaustive_stim_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int HOLD_W = 16;

endpackage

// File: rtl/exhaustive_stim_gen_hold_counter.sv
// Free-running hold counter that wraps to zero after HOLD_CYCLES counts and
// flags its final count so the sequencer can advance the vector.
module hold_counter
   import exhaustive_stim_gen_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic terminal
);

   localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(HOLD_CYCLES - 1);

   logic [HOLD_W-1:0] count;

   assign terminal = (count == LIMIT);

   // Clear dominates enable so the count is parked at zero outside a run.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en) begin
         if (terminal) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/exhaustive_stim_gen.sv
// Restartable, pausable source that walks every WIDTH-bit vector in ascending
// order, holding each for HOLD_CYCLES clocks and strobing sample on the last.
module exhaustive_stim_gen
   import exhaustive_stim_gen_pkg::*;
#(
   parameter int          WIDTH       = 5,
   parameter int unsigned HOLD_CYCLES = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] vec_out,
   output logic             vec_valid,
   output logic             sample,
   output logic             busy,
   output logic             done
);

   // One extra index bit keeps the terminal compare clear of wrap-around.
   localparam logic [WIDTH:0] LAST_INDEX = {1'b0, {WIDTH{1'b1}}};

   state_t         state;
   state_t         state_next;
   logic [WIDTH:0] index;
   logic [WIDTH:0] index_next;
   logic           hold_en;
   logic           hold_clr;
   logic           terminal;

   hold_counter #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold (
      .clk     (clk),
      .reset   (reset),
      .en      (hold_en),
      .clr     (hold_clr),
      .terminal(terminal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         index <= '0;
      end else begin
         state <= state_next;
         index <= index_next;
      end
   end

   always_comb begin
      state_next = state;
      index_next = index;
      hold_en    = 1'b0;
      hold_clr   = 1'b1;
      vec_out    = '0;
      vec_valid  = 1'b0;
      sample     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               index_next = '0;
            end
         end
         ST_RUN: begin
            hold_clr  = 1'b0;
            vec_out   = index[WIDTH-1:0];
            vec_valid = 1'b1;
            busy      = 1'b1;
            // A paused cycle neither counts nor strobes; the strobe recurs once released.
            if (!pause) begin
               hold_en = 1'b1;
               if (terminal) begin
                  sample     = 1'b1;
                  index_next = index + 1'b1;
                  if (index == LAST_INDEX) begin
                     state_next = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               state_next = ST_RUN;
               index_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Directed bench for exhaustive_stim_gen: a default-parameter instance for
// full runs, pause, restart and reset, plus a WIDTH=3 / HOLD_CYCLES=1 instance.
module tb_exhaustive_stim_gen;

   logic       clk = 1'b0;
   logic       reset, start, pause;
   logic [4:0] vec_out;
   logic       vec_valid, sample, busy, done;

   logic       reset2, start2, pause2;
   logic [2:0] vec_out2;
   logic       vec_valid2, sample2, busy2, done2;

   int testsRun  = 0;
   int failCount = 0;
   int cycles, samples, vec5Cycles;

   always #5 clk = ~clk;

   exhaustive_stim_gen dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pause    (pause),
      .vec_out  (vec_out),
      .vec_valid(vec_valid),
      .sample   (sample),
      .busy     (busy),
      .done     (done)
   );

   exhaustive_stim_gen #(
      .WIDTH      (3),
      .HOLD_CYCLES(1)
   ) dut2 (
      .clk      (clk),
      .reset    (reset2),
      .start    (start2),
      .pause    (pause2),
      .vec_out  (vec_out2),
      .vec_valid(vec_valid2),
      .sample   (sample2),
      .busy     (busy2),
      .done     (done2)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic p);
      reset = r;
      start = s;
      pause = p;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Walks the default instance from the cycle after a start until done,
   // optionally pausing for a window and pulsing start once mid-run.
   task automatic runToDone(input int pauseAt, input int pauseLen, input int startAt,
                            output int nCycles, output int nSamples, output int nVec5);
      int c = 0;
      nSamples = 0;
      nVec5    = 0;
      while (!done && c < 2000) begin
         pause = (pauseAt >= 0 && c >= pauseAt && c < pauseAt + pauseLen);
         start = (c == startAt);
         #1;
         if (vec_out == 5'd5) nVec5++;
         if (pause) checkOutput("no_sample_paused", 32'(sample), 32'd0);
         if (sample) begin
            checkOutput("sample_vec", 32'(vec_out), 32'(nSamples));
            nSamples++;
         end
         step(1);
         c++;
      end
      pause   = 1'b0;
      start   = 1'b0;
      nCycles = c;
      checkOutput("run_bounded", 32'(done), 32'd1);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      reset2 = 1'b1;
      start2 = 1'b0;
      pause2 = 1'b0;
      step(2);

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0);
      reset2 = 1'b0;
      checkOutput("rst_vec_out", 32'(vec_out), 32'd0);
      checkOutput("rst_vec_valid", 32'(vec_valid), 32'd0);
      checkOutput("rst_sample", 32'(sample), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);

      // Reset and start together: reset wins
      applyStimulus(1'b1, 1'b1, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rst_start_busy", 32'(busy), 32'd0);
      step(1);
      checkOutput("rst_start_idle", 32'(vec_valid), 32'd0);

      // Full default run
      start = 1'b1;
      step(1);
      start = 1'b0;
      checkOutput("start_vec_out", 32'(vec_out), 32'd0);
      checkOutput("start_vec_valid", 32'(vec_valid), 32'd1);
      checkOutput("start_busy", 32'(busy), 32'd1);
      runToDone(-1, 0, -1, cycles, samples, vec5Cycles);
      checkOutput("run1_cycles", 32'(cycles), 32'd640);
      checkOutput("run1_samples", 32'(samples), 32'd32);
      checkOutput("run1_vec5_len", 32'(vec5Cycles), 32'd20);
      checkOutput("done_vec_out", 32'(vec_out), 32'd0);
      checkOutput("done_vec_valid", 32'(vec_valid), 32'd0);
      checkOutput("done_busy", 32'(busy), 32'd0);
      step(3);
      checkOutput("done_level", 32'(done), 32'd1);

      // Restart from DONE, then pause during vector 5 and pulse start in vector 9
      start = 1'b1;
      step(1);
      start = 1'b0;
      checkOutput("restart_done_drop", 32'(done), 32'd0);
      checkOutput("restart_busy", 32'(busy), 32'd1);
      checkOutput("restart_vec_out", 32'(vec_out), 32'd0);
      runToDone(110, 7, 192, cycles, samples, vec5Cycles);
      checkOutput("run2_cycles", 32'(cycles), 32'd647);
      checkOutput("run2_samples", 32'(samples), 32'd32);
      checkOutput("run2_vec5_len", 32'(vec5Cycles), 32'd27);

      // Reset in the middle of vector 17, then restart
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(343);
      checkOutput("pre_reset_vec", 32'(vec_out), 32'd17);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checkOutput("midrst_vec_out", 32'(vec_out), 32'd0);
      checkOutput("midrst_vec_valid", 32'(vec_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      step(3);
      checkOutput("midrst_idle", 32'(busy), 32'd0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      checkOutput("rerun_vec_out", 32'(vec_out), 32'd0);
      checkOutput("rerun_vec_valid", 32'(vec_valid), 32'd1);
      step(19);
      checkOutput("rerun_vec0_last", 32'(vec_out), 32'd0);
      checkOutput("rerun_sample", 32'(sample), 32'd1);
      step(1);
      checkOutput("rerun_vec1", 32'(vec_out), 32'd1);

      // WIDTH=3, HOLD_CYCLES=1 instance
      start2 = 1'b1;
      step(1);
      start2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkOutput("w3_vec_out", 32'(vec_out2), 32'(i));
         checkOutput("w3_sample", 32'(sample2), 32'd1);
         checkOutput("w3_busy", 32'(busy2), 32'd1);
         step(1);
      end
      checkOutput("w3_done", 32'(done2), 32'd1);
      checkOutput("w3_done_valid", 32'(vec_valid2), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
